sram_frame_writer: RTL and testbench

- Converts an 8-bit pixel stream from the capture/feature pipeline into 54-bit SRAM write requests.
- Request format is {mask[3:0], addr[17:0], data[31:0]}. It drives one write port (w0 or w1) of the SRAM arbiter.
- Packs 4 pixels per 32-bit word and generates word addresses.
- Ping-pongs between two frame buffers so the read side can consume the last completed frame.

---
 rtl/sram_frame_writer.sv | 149 ++++++++++++++
 tb/tb_sram_frame_writer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_frame_writer.sv
// sram_frame_writer
//   Packs an 8-bit pixel stream into 32-bit little-endian words and issues them
//   as 54-bit SRAM write requests {mask[3:0], addr[17:0], data[31:0]} on one
//   arbiter write port. Frames alternate between two buffers (BASE0/BASE1) so a
//   reader can consume the most recently completed frame.
//
// Ports
//   clock, reset       : rising-edge clock, asynchronous active-high reset
//   pix_valid/ready    : pixel stream handshake (ready is combinational)
//   pix_data, pix_sof  : pixel value, first-pixel-of-frame qualifier
//   w_din_valid/ready  : registered write request handshake to the arbiter
//   w_din              : {mask, addr, data}
//   frame_done         : 1-cycle pulse after the last pixel of a frame
//   done_buffer        : buffer index of the most recently completed frame
//   sync_error         : 1-cycle pulse after an SOF arrives mid-frame
module sram_frame_writer #(
  parameter int          FRAME_PIXELS = 480000,
  parameter logic [17:0] BASE0        = 18'd0,
  parameter logic [17:0] BASE1        = 18'd120000,
  parameter int          PIX_CNT_W    = 19
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_data,
  input  logic        pix_sof,
  output logic        w_din_valid,
  input  logic        w_din_ready,
  output logic [53:0] w_din,
  output logic        frame_done,
  output logic        done_buffer,
  output logic        sync_error
);

  localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(FRAME_PIXELS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [3:0]  mask;
    logic [17:0] addr;
    logic [31:0] data;
  } wreq_t;

  state_t               state_q;
  logic                 cur_buf_q;
  logic [17:0]          addr_q;
  logic [1:0]           byte_cnt_q;
  logic [PIX_CNT_W-1:0] pix_cnt_q;
  logic [31:0]          asm_q;
  logic                 w_din_valid_q;
  wreq_t                w_din_q;
  logic                 frame_done_q;
  logic                 done_buffer_q;
  logic                 sync_error_q;

  // Per-pixel datapath: an SOF pixel restarts the frame, so every "effective"
  // value collapses to the pixel-0 view regardless of current progress.
  logic                 take;
  logic [1:0]           eff_byte;
  logic [PIX_CNT_W-1:0] eff_pix;
  logic [17:0]          eff_addr;
  logic [17:0]          cur_base;
  logic [17:0]          next_base;
  logic [31:0]          merged;
  logic [3:0]           mask_d;
  logic                 is_last;
  logic                 load;

  // Any pixel is stalled only while the output register holds an undrained word.
  assign pix_ready = !w_din_valid_q || w_din_ready;

  always_comb begin
    cur_base  = cur_buf_q ? BASE1 : BASE0;
    next_base = cur_buf_q ? BASE0 : BASE1;
    // In IDLE only an SOF pixel is used; the rest are accepted and dropped.
    take      = pix_valid && pix_ready && (state_q == RUN || pix_sof);
    eff_byte  = pix_sof ? 2'd0 : byte_cnt_q;
    eff_pix   = pix_sof ? '0 : pix_cnt_q;
    eff_addr  = pix_sof ? cur_base : addr_q;
    merged    = pix_sof ? 32'd0 : asm_q;
    merged[{eff_byte, 3'b000} +: 8] = pix_data;
    is_last   = (eff_pix == LAST_PIX);
    load      = (eff_byte == 2'd3) || is_last;
    unique case (eff_byte)
      2'd0:    mask_d = 4'b0001;
      2'd1:    mask_d = 4'b0011;
      2'd2:    mask_d = 4'b0111;
      default: mask_d = 4'b1111;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cur_buf_q     <= 1'b0;
      addr_q        <= BASE0;
      byte_cnt_q    <= 2'd0;
      pix_cnt_q     <= '0;
      asm_q         <= 32'd0;
      w_din_valid_q <= 1'b0;
      w_din_q       <= '0;
      frame_done_q  <= 1'b0;
      done_buffer_q <= 1'b0;
      sync_error_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      sync_error_q <= 1'b0;
      if (w_din_ready) w_din_valid_q <= 1'b0;

      if (take) begin
        if (state_q == RUN && pix_sof && pix_cnt_q != '0) sync_error_q <= 1'b1;

        if (load) begin
          // Same-cycle load wins over the drain above: no bubble between words.
          w_din_valid_q <= 1'b1;
          w_din_q       <= '{mask: mask_d, addr: eff_addr, data: merged};
          asm_q         <= 32'd0;
          byte_cnt_q    <= 2'd0;
          addr_q        <= eff_addr + 18'd1;
        end else begin
          asm_q         <= merged;
          byte_cnt_q    <= eff_byte + 2'd1;
          addr_q        <= eff_addr;
        end

        if (is_last) begin
          frame_done_q  <= 1'b1;
          done_buffer_q <= cur_buf_q;
          cur_buf_q     <= ~cur_buf_q;
          addr_q        <= next_base;
          pix_cnt_q     <= '0;
          state_q       <= IDLE;
        end else begin
          pix_cnt_q     <= eff_pix + PIX_CNT_W'(1);
          state_q       <= RUN;
        end
      end
    end
  end

  assign w_din_valid = w_din_valid_q;
  assign w_din       = w_din_q;
  assign frame_done  = frame_done_q;
  assign done_buffer = done_buffer_q;
  assign sync_error  = sync_error_q;

endmodule

// File: tb/tb_sram_frame_writer.sv
module tb_sram_frame_writer;
  localparam int          FP = 10;
  localparam logic [17:0] B0 = 18'h100;
  localparam logic [17:0] B1 = 18'h200;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  pix_data = 8'd0;
  logic        pix_sof = 1'b0;
  logic        w_din_valid;
  logic        w_din_ready = 1'b1;
  logic [53:0] w_din;
  logic        frame_done;
  logic        done_buffer;
  logic        sync_error;

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;
  int se_cnt = 0;
  logic [53:0] exp_q[$];

  sram_frame_writer #(.FRAME_PIXELS(FP), .BASE0(B0), .BASE1(B1), .PIX_CNT_W(19)) dut (
    .clock(clock), .reset(reset),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_sof(pix_sof),
    .w_din_valid(w_din_valid), .w_din_ready(w_din_ready), .w_din(w_din),
    .frame_done(frame_done), .done_buffer(done_buffer), .sync_error(sync_error)
  );

  always #5 clock = ~clock;

  // One clock: observe at the falling edge (scoreboard pop on write handshake),
  // then return 1 time unit after the rising edge.
  task automatic step(output logic acc);
    logic [53:0] exp;
    @(negedge clock);
    acc = pix_valid && pix_ready;
    if (w_din_valid && w_din_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got=%h", w_din);
      end else begin
        exp = exp_q.pop_front();
        if (w_din !== exp) begin
          errors++;
          $display("FAIL wr_data got=%h exp=%h", w_din, exp);
        end
      end
    end
    if (frame_done === 1'b1) fd_cnt++;
    if (sync_error === 1'b1) se_cnt++;
    @(posedge clock);
    #1;
  endtask

  task automatic tick();
    logic a;
    step(a);
  endtask

  task automatic send(input logic [7:0] d, input logic sof);
    logic acc;
    int   n;
    n = 0;
    pix_valid = 1'b1; pix_data = d; pix_sof = sof;
    do begin
      step(acc);
      n++;
    end while (!acc && n < 50);
    pix_valid = 1'b0; pix_sof = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout pixel=%h", d);
    end
  endtask

  // Reference packing: consecutive pixel values start, start+1, ...
  task automatic push_frame(input logic [7:0] start, input logic [17:0] base, input int npix);
    logic [31:0] data;
    logic [3:0]  mask;
    logic [7:0]  px;
    for (int w = 0; w * 4 < npix; w++) begin
      data = 32'd0; mask = 4'd0;
      for (int k = 0; k < 4; k++) begin
        if (w * 4 + k < npix) begin
          px = start + 8'(w * 4 + k);
          data[k*8 +: 8] = px;
          mask[k] = 1'b1;
        end
      end
      exp_q.push_back({mask, base + 18'(w), data});
    end
  endtask

  task automatic send_frame(input logic [7:0] start, input logic [17:0] base, input logic exp_buf);
    push_frame(start, base, FP);
    for (int i = 0; i < FP; i++) begin
      send(start + 8'(i), i == 0);
      if (i == 3) begin
        checks++;
        if (w_din_valid !== 1'b1) begin
          errors++;
          $display("FAIL word_latency w_din_valid=%b exp=1", w_din_valid);
        end
      end
    end
    checks++;
    if (frame_done !== 1'b1 || done_buffer !== exp_buf) begin
      errors++;
      $display("FAIL frame_done got=%b/%b exp=1/%b", frame_done, done_buffer, exp_buf);
    end
  endtask

  task automatic drain(input string name);
    pix_valid = 1'b0; w_din_ready = 1'b1;
    repeat (6) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_words left=%0d exp=0", name, exp_q.size());
    end
  endtask

  task automatic do_reset();
    pix_valid = 1'b0; pix_sof = 1'b0; w_din_ready = 1'b1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    w_din_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h01 + 8'(i), i == 0);
    checks++;
    if (w_din_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_setup w_din_valid=%b exp=1", w_din_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (w_din_valid !== 1'b0 || frame_done !== 1'b0 || sync_error !== 1'b0 ||
        done_buffer !== 1'b0 || pix_ready !== 1'b1 || w_din !== 54'd0) begin
      errors++;
      $display("FAIL async_reset valid=%b fd=%b se=%b db=%b rdy=%b din=%h exp=0,0,0,0,1,0",
               w_din_valid, frame_done, sync_error, done_buffer, pix_ready, w_din);
    end
    @(posedge clock);
    #1;
    reset = 1'b0; w_din_ready = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_frame();
    int fd0;
    do_reset();
    fd0 = fd_cnt;
    send_frame(8'h01, B0, 1'b0);
    drain("frame");
    checks++;
    if (fd_cnt - fd0 != 1) begin
      errors++;
      $display("FAIL frame_done_count got=%0d exp=1", fd_cnt - fd0);
    end
  endtask

  task automatic test_pingpong();
    int fd0;
    fd0 = fd_cnt;
    send_frame(8'h11, B1, 1'b1);
    send_frame(8'h21, B0, 1'b0);
    drain("pingpong");
    checks++;
    if (fd_cnt - fd0 != 2) begin
      errors++;
      $display("FAIL pingpong_done_count got=%0d exp=2", fd_cnt - fd0);
    end
  endtask

  task automatic test_stall();
    do_reset();
    push_frame(8'h01, B0, FP);
    for (int i = 0; i < 4; i++) send(8'h01 + 8'(i), i == 0);
    w_din_ready = 1'b0;
    pix_valid = 1'b1; pix_data = 8'h05; pix_sof = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      checks++;
      if (w_din_valid !== 1'b1 || w_din !== {4'hF, B0, 32'h04030201} || pix_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d valid=%b din=%h rdy=%b exp=1,%h,0",
                 c, w_din_valid, w_din, pix_ready, {4'hF, B0, 32'h04030201});
      end
      @(posedge clock);
      #1;
    end
    w_din_ready = 1'b1;
    for (int i = 4; i < FP; i++) send(8'h01 + 8'(i), 1'b0);
    checks++;
    if (frame_done !== 1'b1 || done_buffer !== 1'b0) begin
      errors++;
      $display("FAIL stall_frame_done got=%b/%b exp=1/0", frame_done, done_buffer);
    end
    drain("stall");
  endtask

  task automatic test_garbage();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pix_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_ready got=%b exp=1", pix_ready);
      end
      send(8'hE0 + 8'(i), 1'b0);
    end
    send_frame(8'h01, B0, 1'b0);
    drain("garbage");
  endtask

  task automatic test_sync();
    int se0;
    do_reset();
    se0 = se_cnt;
    exp_q.push_back({4'hF, B0, 32'h04030201});
    for (int i = 0; i < 5; i++) send(8'h01 + 8'(i), i == 0);
    push_frame(8'hAA, B0, FP);
    send(8'hAA, 1'b1);
    checks++;
    if (sync_error !== 1'b1) begin
      errors++;
      $display("FAIL sync_error_pulse got=%b exp=1", sync_error);
    end
    for (int i = 1; i < FP; i++) send(8'hAA + 8'(i), 1'b0);
    checks++;
    if (frame_done !== 1'b1 || done_buffer !== 1'b0) begin
      errors++;
      $display("FAIL sync_frame_done got=%b/%b exp=1/0", frame_done, done_buffer);
    end
    drain("sync");
    checks++;
    if (se_cnt - se0 != 1) begin
      errors++;
      $display("FAIL sync_error_count got=%0d exp=1", se_cnt - se0);
    end
  endtask

  initial begin
    #12;
    test_reset();
    test_frame();
    test_pingpong();
    test_stall();
    test_garbage();
    test_sync();
    checks++;
    if (se_cnt != 1) begin
      errors++;
      $display("FAIL sync_error_total got=%0d exp=1", se_cnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
